// File: rtl/mips_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_pkg: shared widths, memory-FSM states and pipeline-register fields  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
    } mem_wb_ctrl_t;

    function automatic logic is_mem_op(input ex_mem_ctrl_t c);
        return c.valid & (c.mem_read | c.mem_write);
    endfunction

    // A simultaneous read/write is treated as a store, so it never returns load data.
    function automatic logic is_load(input ex_mem_ctrl_t c);
        return c.valid & c.mem_read & ~c.mem_write;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_fsm: data-memory handshake, stall generation, optional abort  |
// | Timeout counter/ABORT built only with MEM_STAGE_TIMEOUT_EN. Rev: 1.0     |
// +--------------------------------------------------------------------------+
module mem_access_fsm #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_op,
    input  logic dmem_ready,
    output logic stall,
    output logic dmem_req,
    output logic abort,
    output logic mem_fault
);
    import mips_pkg::*;

    mem_state_e state_q;

    assign abort    = (state_q == ABORT);
    assign dmem_req = mem_op & ~abort;
    assign stall    = dmem_req & ~dmem_ready;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             fault_q;

    // Count of stalled cycles including the current one.
    assign cnt_d = (state_q == WAIT) ? cnt_q + 1'b1 : CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            case (state_q)
                IDLE, WAIT: begin
                    if (stall) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                            state_q <= ABORT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign mem_fault = fault_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= stall ? WAIT : IDLE;
        end
    end

    assign mem_fault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage: MIPS MEM stage - EX/MEM and MEM/WB registers, dmem port, fwd  |
// | Optional access timeout via MEM_STAGE_TIMEOUT_EN. Revision: 1.0          |
// +--------------------------------------------------------------------------+
module mem_stage #(
    parameter int DATA_W         = mips_pkg::DATA_W,
    parameter int REG_W          = mips_pkg::REG_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_dest_reg,
    input  logic              flush,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              fwd_valid,
    output logic              fwd_is_load,
    output logic [REG_W-1:0]  fwd_dest,
    output logic [DATA_W-1:0] fwd_value,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_W-1:0]  wb_dest,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic              mem_fault
);
    import mips_pkg::*;

    ex_mem_ctrl_t      m_ctrl_q;
    logic [DATA_W-1:0] m_alu_q;
    logic [DATA_W-1:0] m_store_q;
    logic [REG_W-1:0]  m_dest_q;

    mem_wb_ctrl_t      wb_ctrl_q;
    logic [REG_W-1:0]  wb_dest_q;
    logic [DATA_W-1:0] wb_alu_q;
    logic [DATA_W-1:0] wb_mdata_q;

    logic mem_op;
    logic abort;

    assign mem_op = is_mem_op(m_ctrl_q);

    mem_access_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .mem_op    (mem_op),
        .dmem_ready(dmem_ready),
        .stall     (stall),
        .dmem_req  (dmem_req),
        .abort     (abort),
        .mem_fault (mem_fault)
    );

    // A stalled entry must stay put, so flush only takes effect when the stage advances.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ctrl_q  <= '0;
            m_alu_q   <= '0;
            m_store_q <= '0;
            m_dest_q  <= '0;
        end else if (!stall) begin
            if (flush) begin
                m_ctrl_q <= '0;
            end else begin
                m_ctrl_q  <= '{valid:      ex_valid,
                               reg_write:  ex_reg_write,
                               mem_to_reg: ex_mem_to_reg,
                               mem_read:   ex_mem_read,
                               mem_write:  ex_mem_write};
                m_alu_q   <= ex_alu_result;
                m_store_q <= ex_store_data;
                m_dest_q  <= ex_dest_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_ctrl_q  <= '0;
            wb_dest_q  <= '0;
            wb_alu_q   <= '0;
            wb_mdata_q <= '0;
        end else if (stall || abort) begin
            wb_ctrl_q <= '0;
        end else begin
            wb_ctrl_q  <= '{valid:      m_ctrl_q.valid,
                           reg_write:  m_ctrl_q.reg_write,
                           mem_to_reg: m_ctrl_q.mem_to_reg};
            wb_dest_q  <= m_dest_q;
            wb_alu_q   <= m_alu_q;
            wb_mdata_q <= is_load(m_ctrl_q) ? dmem_rdata : '0;
        end
    end

    assign dmem_we    = m_ctrl_q.mem_write;
    assign dmem_addr  = m_alu_q;
    assign dmem_wdata = m_store_q;

    assign fwd_valid   = m_ctrl_q.valid & m_ctrl_q.reg_write;
    assign fwd_is_load = m_ctrl_q.mem_read;
    assign fwd_dest    = m_dest_q;
    assign fwd_value   = m_alu_q;

    assign wb_valid      = wb_ctrl_q.valid;
    assign wb_reg_write  = wb_ctrl_q.reg_write;
    assign wb_mem_to_reg = wb_ctrl_q.mem_to_reg;
    assign wb_dest       = wb_dest_q;
    assign wb_alu_result = wb_alu_q;
    assign wb_mem_data   = wb_mdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_stage: directed + randomized bench against an instruction model   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_stage;
    localparam int DATA_W         = 32;
    localparam int REG_W          = 5;
    localparam int TIMEOUT_CYCLES = 4;
`ifdef MEM_STAGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
    logic [DATA_W-1:0] ex_alu_result, ex_store_data;
    logic [REG_W-1:0]  ex_dest_reg;
    logic flush;
    logic stall, dmem_req, dmem_we;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata;
    logic dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;
    logic fwd_valid, fwd_is_load;
    logic [REG_W-1:0]  fwd_dest;
    logic [DATA_W-1:0] fwd_value;
    logic wb_valid, wb_reg_write, wb_mem_to_reg;
    logic [REG_W-1:0]  wb_dest;
    logic [DATA_W-1:0] wb_alu_result, wb_mem_data;
    logic mem_fault;

    always #5 clk = ~clk;

    mem_stage #(
        .DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_dest_reg(ex_dest_reg),
        .flush(flush), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .fwd_valid(fwd_valid), .fwd_is_load(fwd_is_load), .fwd_dest(fwd_dest), .fwd_value(fwd_value),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_dest(wb_dest), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .mem_fault(mem_fault)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the instruction currently in the memory stage and how long it has waited.
    typedef struct {
        bit        valid, rw, m2r, rd, wr;
        bit [31:0] alu, sd;
        bit [4:0]  dst;
    } instr_t;

    instr_t    cur;
    int        waited;
    bit        aborting;
    bit        e_wb_valid, e_wb_rw, e_wb_m2r;
    bit [4:0]  e_wb_dst;
    bit [31:0] e_wb_alu, e_wb_md;

    int n_req, n_stall, n_wbv, n_fault;

    task automatic model_reset();
        cur = '{default: 0};
        waited = 0;
        aborting = 0;
        e_wb_valid = 0; e_wb_rw = 0; e_wb_m2r = 0;
        e_wb_dst = 0; e_wb_alu = 0; e_wb_md = 0;
    endtask

    task automatic clear_counts();
        n_req = 0; n_stall = 0; n_wbv = 0; n_fault = 0;
    endtask

    task automatic set_ex(input bit v, rw, m2r, rd, wr, input bit [31:0] alu, sd, input bit [4:0] dst);
        ex_valid = v; ex_reg_write = rw; ex_mem_to_reg = m2r;
        ex_mem_read = rd; ex_mem_write = wr;
        ex_alu_result = alu; ex_store_data = sd; ex_dest_reg = dst;
    endtask

    task automatic set_nop();
        set_ex(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic tick();
        bit op, req, stl;
        #3;
        op  = cur.valid && (cur.rd || cur.wr);
        req = op && !aborting;
        stl = req && !dmem_ready;
        check("stall", stall, stl);
        check("dmem_req", dmem_req, req);
        check("dmem_we", dmem_we, cur.wr);
        if (req) begin
            check("dmem_addr", dmem_addr, cur.alu);
            check("dmem_wdata", dmem_wdata, cur.sd);
        end
        check("fwd_valid", fwd_valid, cur.valid && cur.rw);
        check("fwd_is_load", fwd_is_load, cur.rd);
        if (cur.valid && cur.rw) begin
            check("fwd_dest", fwd_dest, cur.dst);
            check("fwd_value", fwd_value, cur.alu);
        end
        check("wb_valid", wb_valid, e_wb_valid);
        check("wb_reg_write", wb_reg_write, e_wb_rw);
        if (e_wb_valid) begin
            check("wb_mem_to_reg", wb_mem_to_reg, e_wb_m2r);
            check("wb_dest", wb_dest, e_wb_dst);
            check("wb_alu_result", wb_alu_result, e_wb_alu);
            check("wb_mem_data", wb_mem_data, e_wb_md);
        end
        check("mem_fault", mem_fault, aborting);
        n_req   += int'(dmem_req);
        n_stall += int'(stall);
        n_wbv   += int'(wb_valid);
        n_fault += int'(mem_fault);

        @(posedge clk);
        if (stl) begin
            e_wb_valid = 0; e_wb_rw = 0;
            waited++;
            aborting = TO_EN && (waited == TIMEOUT_CYCLES);
        end else begin
            if (aborting) begin
                e_wb_valid = 0; e_wb_rw = 0;
            end else begin
                e_wb_valid = cur.valid; e_wb_rw = cur.rw; e_wb_m2r = cur.m2r;
                e_wb_dst = cur.dst; e_wb_alu = cur.alu;
                e_wb_md = (cur.valid && cur.rd && !cur.wr) ? dmem_rdata : 32'h0;
            end
            if (flush) cur = '{default: 0};
            else cur = '{valid: ex_valid, rw: ex_reg_write, m2r: ex_mem_to_reg,
                         rd: ex_mem_read, wr: ex_mem_write,
                         alu: ex_alu_result, sd: ex_store_data, dst: ex_dest_reg};
            waited = 0;
            aborting = 0;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        set_nop();
        model_reset();
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", stall, 1'b0);
        check("reset_dmem_req", dmem_req, 1'b0);
        check("reset_fwd_valid", fwd_valid, 1'b0);
        check("reset_wb_valid", wb_valid, 1'b0);
        check("reset_wb_alu_result", wb_alu_result, 32'h0);
        check("reset_mem_fault", mem_fault, 1'b0);
        reset = 1'b0;
        tick();

        // ALU result forwarded then written back
        set_ex(1, 1, 0, 0, 0, 32'h0000_002A, 32'h0, 5'd5);
        tick();
        set_nop();
        check("alu_fwd_valid", fwd_valid, 1'b1);
        check("alu_fwd_value", fwd_value, 32'h2A);
        tick();
        check("alu_wb_valid", wb_valid, 1'b1);
        check("alu_wb_alu_result", wb_alu_result, 32'h2A);
        check("alu_wb_dest", wb_dest, 5'd5);
        tick();

        // Load with three wait cycles
        set_ex(1, 1, 1, 1, 0, 32'h100, 32'h0, 5'd7);
        tick();
        set_nop();
        clear_counts();
        repeat (3) tick();
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_ready = 1'b0;
        check("load_wb_mem_data", wb_mem_data, 32'hDEAD_BEEF);
        check("load_wb_valid", wb_valid, 1'b1);
        repeat (2) tick();
        check("load_req_cycles", n_req, 4);
        check("load_stall_cycles", n_stall, 3);
        check("load_wb_valid_cycles", n_wbv, 1);

        // Zero-wait store
        set_ex(1, 0, 0, 0, 1, 32'h200, 32'h1234, 5'd0);
        dmem_ready = 1'b1;
        tick();
        set_nop();
        clear_counts();
        check("store_dmem_we", dmem_we, 1'b1);
        check("store_dmem_wdata", dmem_wdata, 32'h1234);
        tick();
        check("store_wb_reg_write", wb_reg_write, 1'b0);
        check("store_wb_valid", wb_valid, 1'b1);
        tick();
        check("store_stall_cycles", n_stall, 0);
        dmem_ready = 1'b0;

        // Flush while stalled is ignored; flush on an advancing edge inserts a bubble
        set_ex(1, 1, 1, 1, 0, 32'h300, 32'h0, 5'd9);
        tick();
        set_ex(1, 1, 0, 0, 0, 32'h55, 32'h0, 5'd3);
        flush = 1'b1;
        tick();
        check("flush_stalled_addr", dmem_addr, 32'h300);
        check("flush_stalled_req", dmem_req, 1'b1);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hCAFE_0001;
        tick();
        check("flush_bubble_req", dmem_req, 1'b0);
        check("flush_bubble_fwd_valid", fwd_valid, 1'b0);
        flush = 1'b0;
        dmem_ready = 1'b0;
        set_nop();
        tick();

        // Asynchronous reset in the middle of a wait
        set_ex(1, 1, 1, 1, 0, 32'h400, 32'h0, 5'd11);
        tick();
        set_nop();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_req", dmem_req, 1'b0);
        check("rst_mid_stall", stall, 1'b0);
        check("rst_mid_wb_valid", wb_valid, 1'b0);
        check("rst_mid_wb_reg_write", wb_reg_write, 1'b0);
        check("rst_mid_wb_dest", wb_dest, 5'd0);
        check("rst_mid_wb_alu_result", wb_alu_result, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        set_ex(1, 1, 1, 1, 0, 32'h500, 32'h0, 5'd12);
        dmem_ready = 1'b1;
        dmem_rdata = 32'h0BAD_F00D;
        tick();
        set_nop();
        tick();
        check("after_rst_stall", stall, 1'b0);
        dmem_ready = 1'b0;
        tick();

`ifdef MEM_STAGE_TIMEOUT_EN
        // Load never answered: aborted after TIMEOUT_CYCLES stalled cycles
        set_ex(1, 1, 1, 1, 0, 32'h600, 32'h0, 5'd13);
        tick();
        set_nop();
        clear_counts();
        repeat (6) tick();
        check("timeout_stall_cycles", n_stall, 4);
        check("timeout_req_cycles", n_req, 4);
        check("timeout_fault_pulses", n_fault, 1);
        check("timeout_wb_valid_cycles", n_wbv, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            set_ex(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom_range(0, 2) == 0),
                   $urandom, $urandom, 5'($urandom));
            flush = ($urandom_range(0, 7) == 0);
            dmem_ready = 1'($urandom);
            dmem_rdata = $urandom;
            tick();
        end
        flush = 1'b0;
        dmem_ready = 1'b1;
        set_nop();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage MIPS pipeline. It holds the EX/MEM pipeline register, which is fed by the execute stage. It drives a data-memory port with a request/ready handshake and stalls upstream stages while an access waits. It also provides forwarding information, then fills the MEM/WB pipeline register consumed by write-back.

## Interface
Parameters:
- DATA_W, 32, datapath and memory data width
- REG_W, 5, register-index width
- TIMEOUT_CYCLES, 16, wait-cycle limit before an access is aborted (used only with MEM_STAGE_TIMEOUT_EN)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears every register immediately
- ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write  in  1 each  EX control bits
- ex_alu_result  in  DATA_W  ALU result, also the byte address for memory operations
- ex_store_data  in  DATA_W  store data (rt value)
- ex_dest_reg  in  REG_W  destination register
- flush  in  1  load a bubble into EX/MEM on this edge
- stall  out  1  hold PC, IF/ID and ID/EX, and suppress EX outputs
- dmem_req, dmem_we  out  1  memory request; write enable
- dmem_addr, dmem_wdata  out  DATA_W  address and write data (taken from EX/MEM)
- dmem_ready  in  1  access completes in this cycle
- dmem_rdata  in  DATA_W  load data, valid when dmem_ready=1
- fwd_valid  out  1  EX/MEM holds a valid register write
- fwd_is_load  out  1  that write is a load (value not yet available)
- fwd_dest  out  REG_W  destination register of the EX/MEM entry
- fwd_value  out  DATA_W  EX/MEM ALU result
- wb_valid, wb_reg_write, wb_mem_to_reg  out  1 each  MEM/WB control bits
- wb_dest  out  REG_W  MEM/WB destination register
- wb_alu_result, wb_mem_data  out  DATA_W  MEM/WB data
- mem_fault  out  1  one-cycle pulse when an access is aborted

## Operation
- **Memory operation:** mem_op = m_valid & (m_mem_read | m_mem_write), where m_* denote the EX/MEM register fields.
- **Request:** dmem_req = mem_op & (state != ABORT). dmem_we = m_mem_write.
- **Read/write conflict:** when read and write are both set, the write wins. No load data is captured, and wb_mem_data = 0.
- **Stall:** stall = mem_op & ~dmem_ready & (state != ABORT). It is combinational.
- **EX/MEM update:**
  - stall=1: hold the register; flush is ignored.
  - stall=0 and flush=1: capture a bubble (m_valid=0, all control bits 0).
  - Otherwise: capture the ex_* inputs.
- **MEM/WB update:**
  - stall=1 or state=ABORT: capture a bubble (wb_valid=0, wb_reg_write=0).
  - Otherwise: capture the m_* fields. wb_mem_data = dmem_rdata for a load, 0 otherwise.
- **Forwarding:**
  - fwd_valid = m_valid & m_reg_write.
  - fwd_is_load = m_mem_read.
  - fwd_dest and fwd_value are driven directly from EX/MEM.
- **State machine:**
  - IDLE → WAIT on an edge where stall=1. The wait counter loads 1.
  - WAIT stays in WAIT while stall=1, incrementing the counter each cycle.
  - WAIT → IDLE on the edge where dmem_ready=1.
  - WAIT → ABORT (timeout build only) when the counter equals TIMEOUT_CYCLES and dmem_ready=0.
  - ABORT → IDLE unconditionally after one cycle.
- **ABORT cycle:** dmem_req=0, stall=0 and mem_fault=1. The EX/MEM entry is dropped and replaced by the next instruction.

## Timing
- **Reset values:** every output is 0, the FSM is in IDLE and the counter is 0.
- **Reset mid-access:** reset asynchronously drops dmem_req and stall in the same cycle. The pending access is discarded.
- **Non-memory instruction:** captured into EX/MEM at edge N, visible on fwd_* during cycle N..N+1, and on wb_* after edge N+1.
- **Memory access with k wait cycles:**
  - dmem_req is high for k+1 cycles.
  - stall is high for exactly k cycles.
  - wb_* update on the edge of the ready cycle; wb_valid is high for one cycle.
- **Zero-wait access (k=0):** stall never asserts, and throughput is one instruction per cycle.
- **Back-to-back memory operations:** dmem_req stays high across the boundary, with the address changing on the completing edge.
- **dmem_ready without a request:** ignored.

## Configuration
- **MEM_STAGE_TIMEOUT_EN defined:**
  - The wait counter (width $clog2(TIMEOUT_CYCLES+1)) and the ABORT state are built.
  - After TIMEOUT_CYCLES stalled cycles without dmem_ready, the access aborts as described in Operation.
- **MEM_STAGE_TIMEOUT_EN undefined:**
  - No counter and no ABORT state; WAIT persists until dmem_ready.
  - mem_fault is tied to 0.
  - TIMEOUT_CYCLES is still declared but unused.

## Structure
- **Shared package mips_pkg:**
  - FSM state typedef: IDLE, WAIT, ABORT.
  - Width constants DATA_W and REG_W.
  - Typedefs for the EX/MEM and MEM/WB fields.
- **Sub-module mem_access_fsm:**
  - Inputs: mem_op, dmem_ready.
  - Outputs: stall, dmem_req, abort, mem_fault.
  - Owns the state register and the counter.
- **mem_stage itself:** holds both pipeline registers and the forwarding logic.

## Test plan
- **ALU result:** ex_valid=1, reg_write=1, alu_result=0x0000002A, dest=5 → fwd_valid=1 and fwd_value=0x2A after edge 1; wb_alu_result=0x2A, wb_dest=5, wb_valid=1 after edge 2.
- **Load with 3 wait cycles:** load from 0x100; dmem_ready low for 3 cycles, then high with rdata=0xDEADBEEF → dmem_req high 4 cycles, stall high 3 cycles, wb_mem_data=0xDEADBEEF, wb_valid high for exactly 1 cycle.
- **Zero-wait store:** store with wdata=0x1234 and dmem_ready=1 → dmem_we=1, stall never asserted, wb_reg_write=0.
- **Flush:** flush=1 while stalled → EX/MEM unchanged. flush=1 with no stall → next cycle dmem_req=0 and fwd_valid=0.
- **Reset mid-access:** reset asserted mid-WAIT → dmem_req, stall and all wb_* outputs go to 0 before the next edge; after release the FSM is in IDLE.
- **Timeout:** with MEM_STAGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, a load with dmem_ready held at 0 → stall high 4 cycles, then mem_fault=1 for 1 cycle, dmem_req=0 and wb_valid=0.
